// File: rtl/i2c_slave_receiver_pkg.sv
// Shared I2C target definitions: FSM state encoding, default address, ACK level.
// Also imported by the master's control unit so both sides agree on encodings.
package i2c_slave_receiver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDRESS  = 3'd1,
        ST_ACK_ADDR = 3'd2,
        ST_DATA     = 3'd3,
        ST_ACK_DATA = 3'd4,
        ST_IGNORE   = 3'd5
    } state_e;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h27;
    localparam logic       ACK_LEVEL          = 1'b0;
    localparam logic       NACK_LEVEL         = 1'b1;
    localparam logic [3:0] BITS_PER_BYTE      = 4'd8;

    // Address byte hits only for our 7-bit address with R/W = 0 (write).
    function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return (addr_byte[7:1] == own_addr) && (addr_byte[0] == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Multi-flop synchronizer plus edge detect for one bus line; Rise/Fall are
// combinational from the last sync flop and the edge-detect flop.
module i2c_line_sync #(
    parameter int SyncStages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SyncStages-1:0] sync_q;
    logic                  prev_q;

    // Reset to the idle bus level so no phantom edges appear out of reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], line_i};
            prev_q <= sync_q[SyncStages-1];
        end
    end

    assign level_o = sync_q[SyncStages-1];
    assign rise_o  = sync_q[SyncStages-1] & ~prev_q;
    assign fall_o  = ~sync_q[SyncStages-1] & prev_q;

endmodule

// File: rtl/i2c_slave_receiver.sv
// Write-only I2C target: detects START/STOP, ACKs its own write address and
// streams received data bytes out with a one-clock valid strobe.
module i2c_slave_receiver
    import i2c_slave_receiver_pkg::*;
#(
    parameter logic [6:0] SlaveAddress = DEFAULT_SLAVE_ADDR,
    parameter int         SyncStages   = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_drive_low_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       addr_match_o,
    output logic       busy_o,
    output logic       stop_seen_o
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.SyncStages(SyncStages)) u_scl_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .line_i  (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_sync #(.SyncStages(SyncStages)) u_sda_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .line_i  (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic bus_start, bus_stop;
    assign bus_start = sda_fall & scl_lvl;
    assign bus_stop  = sda_rise & scl_lvl;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_low_q, sda_low_d;
    logic       match_q, match_d;
    logic       busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d;
    logic       stop_seen_q, stop_seen_d;
    logic [7:0] shift_in;

    assign shift_in = {shift_q[6:0], sda_lvl};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            sda_low_q   <= 1'b0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            stop_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            sda_low_q   <= sda_low_d;
            match_q     <= match_d;
            busy_q      <= busy_d;
            rx_valid_q  <= rx_valid_d;
            stop_seen_q <= stop_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        sda_low_d   = sda_low_q;
        match_d     = match_q;
        busy_d      = busy_q;
        rx_valid_d  = 1'b0;
        stop_seen_d = 1'b0;

        // Bus conditions override any bit event in the same clock.
        if (bus_stop) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            sda_low_d   = 1'b0;
            match_d     = 1'b0;
            busy_d      = 1'b0;
            stop_seen_d = 1'b1;
        end else if (bus_start) begin
            state_d   = ST_ADDRESS;
            cnt_d     = '0;
            sda_low_d = 1'b0;
            match_d   = 1'b0;
            busy_d    = 1'b1;
        end else begin
            unique case (state_q)
                ST_ADDRESS: begin
                    if (scl_rise && cnt_q < BITS_PER_BYTE) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        if (addr_hit(shift_q, SlaveAddress)) begin
                            state_d   = ST_ACK_ADDR;
                            sda_low_d = (ACK_LEVEL == 1'b0);
                            match_d   = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ACK_ADDR, ST_ACK_DATA: begin
                    if (scl_fall) begin
                        state_d   = ST_DATA;
                        sda_low_d = (NACK_LEVEL == 1'b0);
                        cnt_d     = '0;
                    end
                end
                ST_DATA: begin
                    if (scl_rise && cnt_q < BITS_PER_BYTE) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == BITS_PER_BYTE - 4'd1) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == BITS_PER_BYTE) begin
                        state_d   = ST_ACK_DATA;
                        sda_low_d = (ACK_LEVEL == 1'b0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_drive_low_o = sda_low_q;
    assign rx_data_o       = rx_data_q;
    assign rx_valid_o      = rx_valid_q;
    assign addr_match_o    = match_q;
    assign busy_o          = busy_q;
    assign stop_seen_o     = stop_seen_q;

endmodule
